// File: rtl/rr_grant_arbiter.sv
// Registered N-port arbiter: round-robin or fixed priority, released by
// request drop or by acknowledge pulse. Grants come straight from flops.
module rr_grant_arbiter #(
    parameter int PORTS             = 4,
    parameter bit ROUND_ROBIN       = 1'b1,
    parameter bit BLOCK_ACK         = 1'b0,
    parameter bit LSB_HIGH_PRIORITY = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst_l,
    input  logic [PORTS-1:0]           request,
    input  logic [PORTS-1:0]           acknowledge,
    output logic [PORTS-1:0]           grant,
    output logic                       grant_valid,
    output logic [$clog2(PORTS)-1:0]   grant_encoded
);

    localparam int IW = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam int PW = 1 << IW;

    logic [PORTS-1:0] grant_q, grant_d;
    logic [PORTS-1:0] mask_q, mask_d;
    logic [PORTS-1:0] eff_mask;
    logic             valid_q, valid_d;
    logic [IW-1:0]    enc_q, enc_d;

    logic [PW-1:0]    req_pad;
    logic [PW-1:0]    ack_pad;
    logic [PW-1:0]    masked_pad;
    logic [IW-1:0]    idx_m, idx_u, winner;
    logic             any_m, any_u;
    logic             release_w, arbitrate;

    // Encoders run over a power-of-two width; pad bits are always zero
    function automatic logic [IW-1:0] prio_enc(input logic [PW-1:0] v);
        logic [IW-1:0] idx;
        idx = '0;
        if (LSB_HIGH_PRIORITY) begin
            for (int i = PW - 1; i >= 0; i--) begin
                if (v[i]) idx = IW'(i);
            end
        end else begin
            for (int i = 0; i < PW; i++) begin
                if (v[i]) idx = IW'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [PORTS-1:0] mask_for(input logic [IW-1:0] i);
        logic [PORTS-1:0] m;
        m = '0;
        for (int b = 0; b < PORTS; b++) begin
            if (LSB_HIGH_PRIORITY) m[b] = (b > int'(i));
            else                   m[b] = (b < int'(i));
        end
        return m;
    endfunction

    always_comb begin
        req_pad             = '0;
        ack_pad             = '0;
        req_pad[PORTS-1:0]  = request;
        ack_pad[PORTS-1:0]  = acknowledge;
        eff_mask            = ROUND_ROBIN ? mask_q : '1;
        masked_pad          = '0;
        masked_pad[PORTS-1:0] = request & eff_mask;
    end

    always_comb begin
        any_m  = |masked_pad;
        any_u  = |req_pad;
        idx_m  = prio_enc(masked_pad);
        idx_u  = prio_enc(req_pad);
        winner = any_m ? idx_m : idx_u;
    end

    // In ACK mode the request level of the owner is irrelevant to release
    always_comb begin
        if (BLOCK_ACK) release_w = valid_q & ack_pad[enc_q];
        else           release_w = valid_q & ~req_pad[enc_q];
        arbitrate = ~valid_q | release_w;
    end

    always_comb begin
        grant_d = grant_q;
        valid_d = valid_q;
        enc_d   = enc_q;
        mask_d  = mask_q;
        if (arbitrate) begin
            if (any_u) begin
                valid_d = 1'b1;
                enc_d   = winner;
                mask_d  = mask_for(winner);
                for (int b = 0; b < PORTS; b++) begin
                    grant_d[b] = (winner == IW'(b));
                end
            end else begin
                valid_d = 1'b0;
                enc_d   = '0;
                grant_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            grant_q <= '0;
            valid_q <= 1'b0;
            enc_q   <= '0;
            mask_q  <= '1;
        end else begin
            grant_q <= grant_d;
            valid_q <= valid_d;
            enc_q   <= enc_d;
            mask_q  <= mask_d;
        end
    end

    assign grant         = grant_q;
    assign grant_valid   = valid_q;
    assign grant_encoded = enc_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Bench for rr_grant_arbiter: four configurations against a scan-order
// reference model, directed scenarios followed by random traffic.
module tb_rr_grant_arbiter;

    logic clk = 1'b0;
    logic rst_l;
    always #5 clk = ~clk;

    logic [4:0] req [4];
    logic [4:0] ack [4];

    logic [3:0] g0, g1, g2;
    logic [4:0] g3;
    logic       v0, v1, v2, v3;
    logic [1:0] e0, e1, e2;
    logic [2:0] e3;

    logic [4:0] gnt [4];
    logic [2:0] enc [4];
    logic       vld [4];

    assign gnt[0] = {1'b0, g0};
    assign gnt[1] = {1'b0, g1};
    assign gnt[2] = {1'b0, g2};
    assign gnt[3] = g3;
    assign enc[0] = {1'b0, e0};
    assign enc[1] = {1'b0, e1};
    assign enc[2] = {1'b0, e2};
    assign enc[3] = e3;
    assign vld[0] = v0;
    assign vld[1] = v1;
    assign vld[2] = v2;
    assign vld[3] = v3;

    rr_grant_arbiter #(.PORTS(4), .ROUND_ROBIN(1'b0), .BLOCK_ACK(1'b0),
                       .LSB_HIGH_PRIORITY(1'b0)) u_a (
        .clk(clk), .rst_l(rst_l),
        .request(req[0][3:0]), .acknowledge(ack[0][3:0]),
        .grant(g0), .grant_valid(v0), .grant_encoded(e0));

    rr_grant_arbiter #(.PORTS(4), .ROUND_ROBIN(1'b1), .BLOCK_ACK(1'b1),
                       .LSB_HIGH_PRIORITY(1'b0)) u_b (
        .clk(clk), .rst_l(rst_l),
        .request(req[1][3:0]), .acknowledge(ack[1][3:0]),
        .grant(g1), .grant_valid(v1), .grant_encoded(e1));

    rr_grant_arbiter #(.PORTS(4), .ROUND_ROBIN(1'b1), .BLOCK_ACK(1'b1),
                       .LSB_HIGH_PRIORITY(1'b1)) u_c (
        .clk(clk), .rst_l(rst_l),
        .request(req[2][3:0]), .acknowledge(ack[2][3:0]),
        .grant(g2), .grant_valid(v2), .grant_encoded(e2));

    rr_grant_arbiter #(.PORTS(5), .ROUND_ROBIN(1'b1), .BLOCK_ACK(1'b0),
                       .LSB_HIGH_PRIORITY(1'b0)) u_d (
        .clk(clk), .rst_l(rst_l),
        .request(req[3]), .acknowledge(ack[3]),
        .grant(g3), .grant_valid(v3), .grant_encoded(e3));

    int NP   [4] = '{4, 4, 4, 5};
    bit RR   [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    bit ACKM [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    bit LSB  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

    // Model: owner index, last winner (-1 = none since reset)
    bit m_vld  [4];
    int m_idx  [4];
    int m_last [4];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h want %0h", tag, got, exp);
        end
    endtask

    // Rotating scan: start just past the last winner in priority direction
    function automatic int pick(input int k, input logic [4:0] r);
        int p;
        p = NP[k];
        if (!RR[k] || m_last[k] < 0) begin
            for (int s = 0; s < p; s++) begin
                int j;
                j = LSB[k] ? s : p - 1 - s;
                if (r[j]) return j;
            end
            return -1;
        end
        for (int s = 1; s <= p; s++) begin
            int j;
            j = LSB[k] ? (m_last[k] + s) % p : (m_last[k] - s + p) % p;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [4:0] pmask(input int k);
        return 5'((1 << NP[k]) - 1);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_vld[k]  = 1'b0;
            m_idx[k]  = 0;
            m_last[k] = -1;
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 4; k++) begin
            logic [4:0] eg;
            eg = m_vld[k] ? 5'(1 << m_idx[k]) : 5'd0;
            check($sformatf("grant%0d", k), 32'(gnt[k]), 32'(eg));
            check($sformatf("valid%0d", k), 32'(vld[k]), 32'(m_vld[k]));
            check($sformatf("enc%0d", k), 32'(enc[k]),
                  m_vld[k] ? 32'(m_idx[k]) : 32'd0);
        end
    endtask

    task automatic tick();
        bit nv [4];
        int ni [4];
        int nl [4];
        for (int k = 0; k < 4; k++) begin
            bit rel;
            int w;
            nv[k] = m_vld[k];
            ni[k] = m_idx[k];
            nl[k] = m_last[k];
            rel = m_vld[k] && (ACKM[k] ? ack[k][m_idx[k]] == 1'b1
                                       : req[k][m_idx[k]] == 1'b0);
            if (!m_vld[k] || rel) begin
                w = pick(k, req[k] & pmask(k));
                if (w >= 0) begin
                    nv[k] = 1'b1;
                    ni[k] = w;
                    nl[k] = w;
                end else begin
                    nv[k] = 1'b0;
                    ni[k] = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            m_vld[k]  = nv[k];
            m_idx[k]  = ni[k];
            m_last[k] = nl[k];
        end
        check_all();
    endtask

    initial begin
        int seqb [5];
        int seqc [4];
        seqb = '{3, 2, 1, 0, 3};
        seqc = '{0, 2, 0, 2};

        rst_l = 1'b0;
        model_reset();
        for (int k = 0; k < 4; k++) begin
            req[k] = pmask(k);
            ack[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_all();
        check("rst_grant_a", 32'(g0), 32'd0);

        @(negedge clk);
        rst_l = 1'b1;
        tick();
        check("first_grant_a", 32'(g0), 32'h8);
        check("first_enc_a", 32'(e0), 32'd3);

        req[0] = 5'b01010;
        tick();
        check("fixed_hi", 32'(g0), 32'h8);
        req[0] = 5'b00010;
        tick();
        check("fixed_nobubble", 32'(g0), 32'h2);
        req[0] = 5'b00000;
        tick();
        check("fixed_idle", 32'(g0), 32'h0);

        req[0] = 5'b00010;
        tick();
        check("hold_own", 32'(g0), 32'h2);
        req[0] = 5'b01010;
        tick();
        check("hold_frozen", 32'(g0), 32'h2);
        req[0] = 5'b01000;
        tick();
        check("hold_handoff", 32'(g0), 32'h8);

        for (int i = 0; i < 5; i++) begin
            check($sformatf("rr_ack_seq%0d", i), 32'(e1), 32'(seqb[i]));
            if (i < 4) begin
                ack[1] = 5'(1 << seqb[i]);
                tick();
                ack[1] = '0;
            end
        end
        ack[1] = 5'b00010;
        tick();
        ack[1] = '0;
        check("rr_ack_foreign", 32'(e1), 32'd3);

        req[2] = 5'b00101;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("lsb_seq%0d", i), 32'(e2), 32'(seqc[i]));
            ack[2] = 5'(1 << seqc[i]);
            tick();
            ack[2] = '0;
        end

        req[0] = 5'b00100;
        tick();
        check("pre_areset", 32'(g0), 32'h4);
        #2;
        rst_l = 1'b0;
        #1;
        check("areset_grant", 32'(g0), 32'h0);
        check("areset_valid", 32'(v0), 32'h0);
        model_reset();
        check_all();
        @(negedge clk);
        rst_l = 1'b1;
        req[0] = 5'b01111;
        tick();
        check("post_areset_enc", 32'(e0), 32'd3);

        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 9) < 3)
                    req[k] = 5'($urandom) & pmask(k);
                ack[k] = '0;
                if (m_vld[k] && $urandom_range(0, 1) == 1)
                    ack[k][m_idx[k]] = 1'b1;
                if ($urandom_range(0, 3) == 0)
                    ack[k] = (ack[k] | 5'($urandom)) & pmask(k);
            end
            if ($urandom_range(0, 99) == 0) begin
                #2;
                rst_l = 1'b0;
                #1;
                model_reset();
                check_all();
                @(negedge clk);
                rst_l = 1'b1;
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
